rv_lsu_wb: RTL and testbench

//  Parametrised load/store unit between the memory stage and the data side: TCM + Wishbone master.

---
 rtl/rv_lsu_wb_if.sv | 25 ++
 rtl/rv_lsu_wb.sv | 196 +++++++++++++++++++
 tb/tb_rv_lsu_wb.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_lsu_wb_if.sv
// Wishbone classic master/slave signal bundle used by the rv_lsu_wb data-side port.
interface rv_lsu_wb_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   o_wb_adr;
   logic [DATA_W-1:0]   o_wb_dat;
   logic [DATA_W-1:0]   i_wb_dat;
   logic                o_wb_we;
   logic [DATA_W/8-1:0] o_wb_sel;
   logic                o_wb_stb;
   logic                o_wb_cyc;
   logic                i_wb_ack;
   logic                i_wb_err;

   modport master (
      output o_wb_adr, o_wb_dat, o_wb_we, o_wb_sel, o_wb_stb, o_wb_cyc,
      input  i_wb_dat, i_wb_ack, i_wb_err
   );

   modport slave (
      input  o_wb_adr, o_wb_dat, o_wb_we, o_wb_sel, o_wb_stb, o_wb_cyc,
      output i_wb_dat, i_wb_ack, i_wb_err
   );
endinterface

// File: rtl/rv_lsu_wb.sv
// Load/store unit: routes core accesses to a 1-cycle TCM or a Wishbone master,
// with lane steering, load extension, misalignment and bus timeout reporting.
module rv_lsu_wb #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TCM_ADDR_W  = 12,
   parameter int TCM_SEL_HI  = 31,
   parameter int TCM_SEL_LO  = 28,
   parameter int TCM_SEL_VAL = 0,
   parameter int TIMEOUT     = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_write,
   input  logic [2:0]            i_req_funct3,
   input  logic [ADDR_W-1:0]     i_req_addr,
   input  logic [DATA_W-1:0]     i_req_wdata,
   output logic                  o_rsp_valid,
   output logic [DATA_W-1:0]     o_rsp_data,
   output logic                  o_rsp_err,
   output logic                  o_tcm_sel,
   output logic                  o_tcm_we,
   output logic [TCM_ADDR_W-1:0] o_tcm_addr,
   output logic [DATA_W/8-1:0]   o_tcm_mask,
   output logic [DATA_W-1:0]     o_tcm_wdata,
   input  logic [DATA_W-1:0]     i_tcm_rdata,
   rv_lsu_wb_if.master           wb
);
   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int SEL_W = TCM_SEL_HI - TCM_SEL_LO + 1;
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [SEL_W-1:0] SEL_VAL = SEL_W'(TCM_SEL_VAL);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_TCM = 2'd1, S_BUS = 2'd2, S_RESP = 2'd3} state_t;

   function automatic logic misaligned(input logic [1:0] sz, input logic [OFF_W-1:0] off);
      misaligned = 1'b0;
      for (int i = 0; i < OFF_W; i++) misaligned = misaligned | (off[i] & (i < int'(sz)));
   endfunction

   function automatic logic [NB-1:0] lane_mask(input logic [1:0] sz, input logic [OFF_W-1:0] off);
      int o;
      int n;
      o = int'(off);
      n = int'(32'd1 << sz);
      for (int i = 0; i < NB; i++) lane_mask[i] = (i >= o) && (i < o + n);
   endfunction

   // Low lane of the store data is replicated so any byte offset sees it.
   function automatic logic [DATA_W-1:0] store_rep(input logic [DATA_W-1:0] wd, input logic [1:0] sz);
      int n;
      n = int'(32'd1 << sz);
      for (int i = 0; i < NB; i++) store_rep[8*i +: 8] = wd[8*(i % n) +: 8];
   endfunction

   function automatic logic [DATA_W-1:0] load_fmt(input logic [DATA_W-1:0] raw, input logic [1:0] sz,
                                                  input logic uns, input logic [OFF_W-1:0] off);
      logic [DATA_W-1:0] sh;
      logic              fill;
      int                n;
      int                sb;
      sh   = raw >> {off, 3'b000};
      n    = int'(32'd1 << sz);
      sb   = (8 * n > DATA_W) ? DATA_W - 1 : 8 * n - 1;
      fill = ~uns & sh[sb];
      for (int i = 0; i < NB; i++) load_fmt[8*i +: 8] = (i < n) ? sh[8*i +: 8] : {8{fill}};
   endfunction

   state_t               state_r, state_s;
   logic                 write_r, uns_r, tcm_r, err_r;
   logic [1:0]           size_r;
   logic [OFF_W-1:0]     off_r;
   logic [CNT_W-1:0]     cnt_r;
   logic [DATA_W-1:0]    rdata_r;
   logic                 tcm_we_r;
   logic [TCM_ADDR_W-1:0] tcm_addr_r;
   logic [NB-1:0]        tcm_mask_r;
   logic [DATA_W-1:0]    tcm_wdata_r;
   logic [ADDR_W-1:0]    wb_adr_r;
   logic [DATA_W-1:0]    wb_dat_r;
   logic                 wb_we_r;
   logic [NB-1:0]        wb_sel_r;

   logic                 accept_s, bad_s, is_tcm_s, timeout_s;
   logic [1:0]           size_s;
   logic [OFF_W-1:0]     off_s;

   assign size_s    = i_req_funct3[1:0];
   assign off_s     = i_req_addr[OFF_W-1:0];
   assign accept_s  = i_req_valid && (state_r == S_IDLE);
   assign bad_s     = misaligned(size_s, off_s) || ((size_s == 2'd3) && (DATA_W < 64));
   assign is_tcm_s  = (i_req_addr[TCM_SEL_HI:TCM_SEL_LO] == SEL_VAL);
   assign timeout_s = (TIMEOUT != 0) && (cnt_r == TO_LAST);

   // Next-state decode; err has priority over ack, and ack over timeout.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (!accept_s)     state_s = S_IDLE;
            else if (bad_s)    state_s = S_RESP;
            else if (is_tcm_s) state_s = S_TCM;
            else               state_s = S_BUS;
         end
         S_TCM:  state_s = S_RESP;
         S_BUS: begin
            if (wb.i_wb_err || wb.i_wb_ack || timeout_s) state_s = S_RESP;
            else                                         state_s = S_BUS;
         end
         S_RESP: state_s = S_IDLE;
         default: state_s = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) state_r <= S_IDLE;
      else         state_r <= state_s;
   end

   // Request capture, TCM/WB output registers, bus completion and timeout counter.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         write_r     <= 1'b0;
         uns_r       <= 1'b0;
         tcm_r       <= 1'b0;
         err_r       <= 1'b0;
         size_r      <= 2'd0;
         off_r       <= '0;
         cnt_r       <= '0;
         rdata_r     <= '0;
         tcm_we_r    <= 1'b0;
         tcm_addr_r  <= '0;
         tcm_mask_r  <= '0;
         tcm_wdata_r <= '0;
         wb_adr_r    <= '0;
         wb_dat_r    <= '0;
         wb_we_r     <= 1'b0;
         wb_sel_r    <= '0;
      end else if (accept_s) begin
         write_r <= i_req_write;
         uns_r   <= i_req_funct3[2];
         size_r  <= size_s;
         off_r   <= off_s;
         tcm_r   <= is_tcm_s;
         err_r   <= bad_s;
         cnt_r   <= '0;
         if (is_tcm_s) begin
            tcm_we_r    <= i_req_write;
            tcm_addr_r  <= i_req_addr[OFF_W +: TCM_ADDR_W];
            tcm_mask_r  <= lane_mask(size_s, off_s);
            tcm_wdata_r <= store_rep(i_req_wdata, size_s);
         end else begin
            wb_adr_r <= {i_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            wb_dat_r <= store_rep(i_req_wdata, size_s);
            wb_we_r  <= i_req_write;
            wb_sel_r <= lane_mask(size_s, off_s);
         end
      end else if (state_r == S_BUS) begin
         if (wb.i_wb_err)      err_r   <= 1'b1;
         else if (wb.i_wb_ack) rdata_r <= wb.i_wb_dat;
         else if (timeout_s)   err_r   <= 1'b1;
         else                  cnt_r   <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // TCM load data arrives in RESP and is formatted without an extra register stage.
   always_comb begin
      o_rsp_data = '0;
      if (o_rsp_valid && !write_r && !err_r)
         o_rsp_data = load_fmt(tcm_r ? i_tcm_rdata : rdata_r, size_r, uns_r, off_r);
      else
         o_rsp_data = '0;
   end

   assign o_req_ready  = ~i_reset & (state_r == S_IDLE);
   assign o_rsp_valid  = ~i_reset & (state_r == S_RESP);
   assign o_rsp_err    = o_rsp_valid & err_r;
   assign o_tcm_sel    = ~i_reset & (state_r == S_TCM);
   assign o_tcm_we     = tcm_we_r;
   assign o_tcm_addr   = tcm_addr_r;
   assign o_tcm_mask   = tcm_mask_r;
   assign o_tcm_wdata  = tcm_wdata_r;
   assign wb.o_wb_adr  = wb_adr_r;
   assign wb.o_wb_dat  = wb_dat_r;
   assign wb.o_wb_we   = wb_we_r;
   assign wb.o_wb_sel  = wb_sel_r;
   assign wb.o_wb_cyc  = ~i_reset & (state_r == S_BUS);
   assign wb.o_wb_stb  = ~i_reset & (state_r == S_BUS);
endmodule

// File: tb/tb_rv_lsu_wb.sv
// Directed bench for rv_lsu_wb: a 32-bit instance for TCM/WB/error paths and a
// 64-bit instance for doubleword and word-extension lane handling.
module tb_rv_lsu_wb;
   logic        clk = 1'b0;
   logic        rst;
   int          checks = 0;
   int          errors = 0;

   logic        valid, write, ready, rsp_valid, rsp_err;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata, rsp_data, tcm_wdata, tcm_rdata;
   logic        tcm_sel, tcm_we;
   logic [11:0] tcm_addr;
   logic [3:0]  tcm_mask;

   logic        d_valid, d_write, d_ready, d_rsp_valid, d_rsp_err;
   logic [2:0]  d_funct3;
   logic [31:0] d_addr;
   logic [63:0] d_wdata, d_rsp_data, d_tcm_wdata, d_tcm_rdata;
   logic        d_tcm_sel, d_tcm_we;
   logic [11:0] d_tcm_addr;
   logic [7:0]  d_tcm_mask;

   rv_lsu_wb_if #(.ADDR_W(32), .DATA_W(32)) wb32 ();
   rv_lsu_wb_if #(.ADDR_W(32), .DATA_W(64)) wb64 ();

   rv_lsu_wb #(.DATA_W(32), .TIMEOUT(16)) dut (
      .i_clk(clk), .i_reset(rst), .i_req_valid(valid), .o_req_ready(ready),
      .i_req_write(write), .i_req_funct3(funct3), .i_req_addr(addr), .i_req_wdata(wdata),
      .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
      .o_tcm_sel(tcm_sel), .o_tcm_we(tcm_we), .o_tcm_addr(tcm_addr), .o_tcm_mask(tcm_mask),
      .o_tcm_wdata(tcm_wdata), .i_tcm_rdata(tcm_rdata), .wb(wb32)
   );

   rv_lsu_wb #(.DATA_W(64), .TIMEOUT(16)) dut64 (
      .i_clk(clk), .i_reset(rst), .i_req_valid(d_valid), .o_req_ready(d_ready),
      .i_req_write(d_write), .i_req_funct3(d_funct3), .i_req_addr(d_addr), .i_req_wdata(d_wdata),
      .o_rsp_valid(d_rsp_valid), .o_rsp_data(d_rsp_data), .o_rsp_err(d_rsp_err),
      .o_tcm_sel(d_tcm_sel), .o_tcm_we(d_tcm_we), .o_tcm_addr(d_tcm_addr), .o_tcm_mask(d_tcm_mask),
      .o_tcm_wdata(d_tcm_wdata), .i_tcm_rdata(d_tcm_rdata), .wb(wb64)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one cycle (caller sits in an idle cycle), return in cycle N+1.
   task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      valid = 1'b1; write = w; funct3 = f3; addr = a; wdata = wd;
      step();
      valid = 1'b0;
   endtask

   task automatic issue64(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [63:0] wd);
      d_valid = 1'b1; d_write = w; d_funct3 = f3; d_addr = a; d_wdata = wd;
      step();
      d_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
      checks++; if (wb32.o_wb_cyc !== 1'b0) begin errors++; $display("FAIL reset_cyc got %b exp 0", wb32.o_wb_cyc); end
      checks++; if (tcm_sel !== 1'b0) begin errors++; $display("FAIL reset_tcm_sel got %b exp 0", tcm_sel); end
      rst = 1'b0;
      #1;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b exp 1", ready); end
   endtask

   task automatic test_tcm_load();
      issue(1'b0, 3'b010, 32'h0000_0010, 32'h0);
      checks++; if (tcm_sel !== 1'b1) begin errors++; $display("FAIL tcm_sel got %b exp 1", tcm_sel); end
      checks++; if (tcm_addr !== 12'h004) begin errors++; $display("FAIL tcm_addr got %h exp 004", tcm_addr); end
      checks++; if (tcm_mask !== 4'hF) begin errors++; $display("FAIL tcm_mask got %h exp f", tcm_mask); end
      checks++; if (tcm_we !== 1'b0) begin errors++; $display("FAIL tcm_we got %b exp 0", tcm_we); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL tcm_busy_ready got %b exp 0", ready); end
      tcm_rdata = 32'hDEAD_BEEF;
      step();
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL tcm_rsp_valid got %b exp 1", rsp_valid); end
      checks++; if (rsp_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL tcm_rsp_data got %h exp deadbeef", rsp_data); end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL tcm_rsp_err got %b exp 0", rsp_err); end
      checks++; if (tcm_sel !== 1'b0) begin errors++; $display("FAIL tcm_sel_one_cycle got %b exp 0", tcm_sel); end
      step();
      checks++; if (rsp_valid !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL tcm_resp_end got valid %b ready %b exp 0 1", rsp_valid, ready); end
   endtask

   task automatic test_wb_load();
      logic [2:0]  f3s [2] = '{3'b000, 3'b100};
      logic [31:0] exps[2] = '{32'hFFFF_FF80, 32'h0000_0080};
      for (int k = 0; k < 2; k++) begin
         issue(1'b0, f3s[k], 32'h8000_0003, 32'h0);
         checks++; if (wb32.o_wb_sel !== 4'b1000) begin errors++; $display("FAIL wbl_sel got %b exp 1000", wb32.o_wb_sel); end
         checks++; if (wb32.o_wb_adr !== 32'h8000_0000) begin errors++; $display("FAIL wbl_adr got %h exp 80000000", wb32.o_wb_adr); end
         checks++; if (wb32.o_wb_we !== 1'b0 || wb32.o_wb_stb !== 1'b1) begin errors++; $display("FAIL wbl_we_stb got %b %b exp 0 1", wb32.o_wb_we, wb32.o_wb_stb); end
         for (int i = 0; i < 3; i++) begin
            checks++; if (wb32.o_wb_cyc !== 1'b1) begin errors++; $display("FAIL wbl_wait_cyc got %b exp 1", wb32.o_wb_cyc); end
            step();
         end
         wb32.i_wb_ack = 1'b1; wb32.i_wb_dat = 32'h80FF_1234;
         step();
         wb32.i_wb_ack = 1'b0;
         checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wbl_rsp_valid got %b exp 1", rsp_valid); end
         checks++; if (rsp_data !== exps[k]) begin errors++; $display("FAIL wbl_data got %h exp %h", rsp_data, exps[k]); end
         checks++; if (rsp_err !== 1'b0 || wb32.o_wb_cyc !== 1'b0) begin errors++; $display("FAIL wbl_err_cyc got %b %b exp 0 0", rsp_err, wb32.o_wb_cyc); end
         step();
      end
   endtask

   task automatic test_wb_store();
      issue(1'b1, 3'b001, 32'h8000_0002, 32'h0000_ABCD);
      checks++; if (wb32.o_wb_sel !== 4'b1100) begin errors++; $display("FAIL wbs_sel got %b exp 1100", wb32.o_wb_sel); end
      checks++; if (wb32.o_wb_dat !== 32'hABCD_ABCD) begin errors++; $display("FAIL wbs_dat got %h exp abcdabcd", wb32.o_wb_dat); end
      checks++; if (wb32.o_wb_we !== 1'b1) begin errors++; $display("FAIL wbs_we got %b exp 1", wb32.o_wb_we); end
      for (int i = 0; i < 2; i++) begin
         checks++; if (wb32.o_wb_cyc !== 1'b1) begin errors++; $display("FAIL wbs_cyc_hold got %b exp 1", wb32.o_wb_cyc); end
         step();
      end
      wb32.i_wb_ack = 1'b1; wb32.i_wb_dat = 32'hFFFF_FFFF;
      step();
      wb32.i_wb_ack = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL wbs_rsp got %b %b exp 1 0", rsp_valid, rsp_err); end
      checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL wbs_rsp_data got %h exp 0", rsp_data); end
      step();
   endtask

   task automatic test_misaligned();
      logic        ws [3] = '{1'b0, 1'b0, 1'b1};
      logic [2:0]  f3s[3] = '{3'b010, 3'b011, 3'b010};
      logic [31:0] as [3] = '{32'h8000_0002, 32'h8000_0000, 32'h0000_0001};
      for (int k = 0; k < 3; k++) begin
         issue(ws[k], f3s[k], as[k], 32'h1234_5678);
         checks++; if (wb32.o_wb_cyc !== 1'b0 || tcm_sel !== 1'b0) begin errors++; $display("FAIL mis_no_access[%0d] got cyc %b sel %b exp 0 0", k, wb32.o_wb_cyc, tcm_sel); end
         checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("FAIL mis_rsp[%0d] got %b %b exp 1 1", k, rsp_valid, rsp_err); end
         step();
         checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mis_ready[%0d] got %b exp 1", k, ready); end
      end
   endtask

   task automatic test_timeout();
      int cyc_cnt = 0;
      logic seen = 1'b0;
      issue(1'b0, 3'b010, 32'h8000_0004, 32'h0);
      for (int k = 0; k < 40; k++) begin
         if (rsp_valid === 1'b1) begin seen = 1'b1; break; end
         if (wb32.o_wb_cyc === 1'b1) cyc_cnt++;
         step();
      end
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL to_rsp_seen got %b exp 1", seen); end
      checks++; if (cyc_cnt != 16) begin errors++; $display("FAIL to_cyc_cycles got %0d exp 16", cyc_cnt); end
      checks++; if (rsp_err !== 1'b1 || wb32.o_wb_cyc !== 1'b0) begin errors++; $display("FAIL to_err got err %b cyc %b exp 1 0", rsp_err, wb32.o_wb_cyc); end
      step();
      // err and ack together
      issue(1'b0, 3'b010, 32'h8000_0000, 32'h0);
      wb32.i_wb_ack = 1'b1; wb32.i_wb_err = 1'b1; wb32.i_wb_dat = 32'h5555_5555;
      step();
      wb32.i_wb_ack = 1'b0; wb32.i_wb_err = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("FAIL err_ack got %b %b exp 1 1", rsp_valid, rsp_err); end
      step();
      // ack on the final timeout cycle still completes cleanly
      issue(1'b0, 3'b010, 32'h8000_0004, 32'h0);
      repeat (15) step();
      checks++; if (wb32.o_wb_cyc !== 1'b1) begin errors++; $display("FAIL to_last_cyc got %b exp 1", wb32.o_wb_cyc); end
      wb32.i_wb_ack = 1'b1; wb32.i_wb_dat = 32'h1234_5678;
      step();
      wb32.i_wb_ack = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL to_ack_wins got %b %b exp 1 0", rsp_valid, rsp_err); end
      checks++; if (rsp_data !== 32'h1234_5678) begin errors++; $display("FAIL to_ack_data got %h exp 12345678", rsp_data); end
      step();
   endtask

   task automatic test_reset_mid_bus();
      issue(1'b0, 3'b010, 32'h8000_0000, 32'h0);
      checks++; if (wb32.o_wb_cyc !== 1'b1) begin errors++; $display("FAIL rmb_cyc_before got %b exp 1", wb32.o_wb_cyc); end
      rst = 1'b1;
      step();
      checks++; if (wb32.o_wb_cyc !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rmb_cyc_after got %b %b exp 0 0", wb32.o_wb_cyc, rsp_valid); end
      rst = 1'b0;
      #1;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rmb_ready got %b exp 1", ready); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (rsp_valid !== 1'b0 || wb32.o_wb_cyc !== 1'b0) begin errors++; $display("FAIL rmb_quiet got %b %b exp 0 0", rsp_valid, wb32.o_wb_cyc); end
      end
   endtask

   task automatic test_back_to_back();
      tcm_rdata = 32'h1122_3344;
      issue(1'b0, 3'b010, 32'h0000_0020, 32'h0);
      valid = 1'b1; write = 1'b1; funct3 = 3'b000; addr = 32'h0000_0021; wdata = 32'h0000_005A;
      step();
      checks++; if (tcm_sel !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL b2b_held got sel %b ready %b exp 0 0", tcm_sel, ready); end
      checks++; if (rsp_data !== 32'h1122_3344 || rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_first got %h %b exp 11223344 1", rsp_data, rsp_valid); end
      step();
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", ready); end
      step();
      valid = 1'b0;
      checks++; if (tcm_sel !== 1'b1 || tcm_we !== 1'b1) begin errors++; $display("FAIL b2b_second got sel %b we %b exp 1 1", tcm_sel, tcm_we); end
      checks++; if (tcm_mask !== 4'b0010 || tcm_addr !== 12'h008) begin errors++; $display("FAIL b2b_mask_addr got %b %h exp 0010 008", tcm_mask, tcm_addr); end
      checks++; if (tcm_wdata !== 32'h5A5A_5A5A) begin errors++; $display("FAIL b2b_wdata got %h exp 5a5a5a5a", tcm_wdata); end
      step();
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0) begin errors++; $display("FAIL b2b_store_rsp got %b %h exp 1 0", rsp_valid, rsp_data); end
      step();
   endtask

   task automatic test_dw64();
      logic [2:0]  f3s [3] = '{3'b011, 3'b010, 3'b110};
      logic [31:0] as  [3] = '{32'h8000_0008, 32'h8000_000C, 32'h8000_000C};
      logic [7:0]  sels[3] = '{8'hFF, 8'hF0, 8'hF0};
      logic [63:0] dats[3] = '{64'h0123_4567_89AB_CDEF, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
      logic [63:0] exps[3] = '{64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000};
      for (int k = 0; k < 3; k++) begin
         issue64(1'b0, f3s[k], as[k], 64'h0);
         checks++; if (wb64.o_wb_sel !== sels[k]) begin errors++; $display("FAIL dw_sel[%0d] got %h exp %h", k, wb64.o_wb_sel, sels[k]); end
         checks++; if (wb64.o_wb_cyc !== 1'b1 || wb64.o_wb_adr !== 32'h8000_0008) begin errors++; $display("FAIL dw_cyc_adr[%0d] got %b %h exp 1 80000008", k, wb64.o_wb_cyc, wb64.o_wb_adr); end
         wb64.i_wb_ack = 1'b1; wb64.i_wb_dat = dats[k];
         step();
         wb64.i_wb_ack = 1'b0;
         checks++; if (d_rsp_valid !== 1'b1 || d_rsp_err !== 1'b0) begin errors++; $display("FAIL dw_rsp[%0d] got %b %b exp 1 0", k, d_rsp_valid, d_rsp_err); end
         checks++; if (d_rsp_data !== exps[k]) begin errors++; $display("FAIL dw_data[%0d] got %h exp %h", k, d_rsp_data, exps[k]); end
         step();
      end
   endtask

   initial begin
      rst = 1'b1;
      valid = 1'b0; write = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0; tcm_rdata = 32'h0;
      d_valid = 1'b0; d_write = 1'b0; d_funct3 = 3'b000; d_addr = 32'h0; d_wdata = 64'h0; d_tcm_rdata = 64'h0;
      wb32.i_wb_ack = 1'b0; wb32.i_wb_err = 1'b0; wb32.i_wb_dat = 32'h0;
      wb64.i_wb_ack = 1'b0; wb64.i_wb_err = 1'b0; wb64.i_wb_dat = 64'h0;
      #1;
      test_reset();
      test_tcm_load();
      test_wb_load();
      test_wb_store();
      test_misaligned();
      test_timeout();
      test_reset_mid_bus();
      test_back_to_back();
      test_dw64();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
